shared_bus_arbiter: RTL
=======================

Name: shared_bus_arbiter

Overview:
- Round-robin arbiter and single-driver mux for a bus shared by N_REQ requesters.
- Replaces multiple continuous assigns onto one net, which resolve to X on a plain wire, with exactly one registered owner.
- Enforces a bounded hold time per owner and one dead (turnaround) cycle between owners, so ownership never overlaps.
- Sits between requester blocks and any downstream consumer of bus_data.

Parameters:
- N_REQ, 4, number of requesters; legal range 1..16.
- DW, 8, bus data width.
- MAX_HOLD, 8, maximum consecutive OWN cycles per grant; legal range 1..256.
- OW, $clog2(N_REQ) with minimum 1, owner index width (derived localparam).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-requester request; bit i belongs to requester i.
- req_data  in  N_REQ*DW  requester i drives bits [i*DW +: DW].
- gnt  out  N_REQ  registered one-hot grant; all-zero when no owner.
- bus_data  out  DW  req_data of the current owner; 0 when gnt==0.
- bus_valid  out  1  high when gnt!=0 and the owner's req is high.
- bus_owner  out  OW  registered index of the current or last owner.
- timeout_pulse  out  1  registered, one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst_n sampled low at an edge):
  - State goes to IDLE.
  - gnt=0, bus_owner=0, timeout_pulse=0.
  - Internal ptr=0, hold_cnt=0.
  - bus_data=0 and bus_valid=0 follow from gnt=0.
  - Reset mid-ownership drops gnt at that same edge; there is no TURN cycle.
- Arbitration function (used in IDLE and TURN):
  - Choose the first i with req[i]=1, scanning ptr, ptr+1, ... and wrapping from N_REQ-1 to 0.
  - If no req bit is set, there is no winner.
- IDLE:
  - Winner found at the edge: gnt<=onehot(i), bus_owner<=i, hold_cnt<=0, go to OWN.
  - Latency: req sampled high at edge k gives gnt visible after edge k (one cycle).
  - No winner: stay in IDLE.
- OWN:
  - hold_cnt increments every edge spent in OWN.
  - Requests from non-owners are ignored; nothing preempts the owner.
  - Owner's req sampled low: go to TURN.
  - Owner's req high and hold_cnt==MAX_HOLD-1: go to TURN and set timeout_pulse<=1 for exactly one cycle.
  - On either exit: gnt<=0 and ptr<=(bus_owner+1) mod N_REQ.
  - bus_owner keeps its value through TURN.
- TURN:
  - Exactly one cycle with gnt=0, bus_data=0, bus_valid=0.
  - At its end edge, run the arbitration function with the new ptr.
  - Winner: go directly to OWN (gnt, bus_owner, hold_cnt updated as in IDLE).
  - No winner: go to IDLE.
- bus_data is a combinational AND-OR mux of req_data gated by gnt. It is never X when the inputs are known, and 0 with no owner.
- bus_valid is combinational: |(gnt & req).
  - An owner that drops req shows bus_valid=0 in that cycle, then TURN follows.
- Boundary conditions:
  - N_REQ=1: ptr is always 0. A continuous req gives MAX_HOLD cycles granted, 1 dead cycle, repeating.
  - MAX_HOLD=1: every grant lasts one cycle; timeout_pulse fires on every handoff where req is still high.
  - A timed-out owner may be re-granted only when no other requester is pending, via the round-robin scan.
- Unused state encoding: return to IDLE with gnt=0.

Decomposition:
- Shared package/include holds:
  - State encoding localparams: IDLE=2'd0, OWN=2'd1, TURN=2'd2.
  - onehot(idx) function.
  - Width helper for OW.
- One sub-module, rr_picker: purely combinational.
  - Inputs: req[N_REQ], ptr[OW].
  - Outputs: found, idx[OW].
  - Instantiated once; the top keeps the FSM, counters and output mux.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with req=4'b1111 -> gnt=0, bus_data=0, bus_valid=0, bus_owner=0, timeout_pulse=0 throughout. The first grant after release goes to requester 0.
2. Single requester: req[2]=1 with req_data[2]=8'hA5 held for 3 cycles, then low.
   - Expected: gnt=4'b0100 one cycle after req rises; bus_data=8'hA5 and bus_valid=1 for 3 cycles.
   - Expected: bus_valid=0 the cycle req drops; then TURN with gnt=0, then IDLE.
3. Saturation: req=4'b1111 constant, MAX_HOLD=8.
   - Expected: owners 0,1,2,3,0,... each hold 8 cycles, with 1 gnt=0 cycle between owners.
   - Expected: timeout_pulse=1 on each of the 4 exits; gnt is never multi-hot.
4. Round-robin wrap: owner 3 releases while req[0] and req[1] are high -> grant to 0. Owner 1 releases while req[0] and req[3] are high -> grant to 3.
5. Reset mid-ownership: requester 1 owns with hold_cnt=4, then rst_n=0 for 1 edge -> gnt=0 at that edge with no TURN. After release, req[1] is re-granted one cycle later.
6. Non-preemption: requester 0 owns, req[2] rises mid-burst -> gnt stays 4'b0001 until req[0] drops or MAX_HOLD is reached; requester 2 is granted immediately after the single TURN cycle.

Source files
------------

// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and helpers for the shared-bus arbiter.
// State encoding, one-hot helper and owner-index width helper.
package shared_bus_arbiter_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  function automatic int ow_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] onehot(
    input int unsigned idx
  );
    logic [MAX_REQ-1:0] one;
    one = {{(MAX_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr.
// Purely combinational; ptr is assumed to be below N_REQ.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int OW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [OW-1:0]    ptr,
  output logic             found,
  output logic [OW-1:0]    idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  // rotate so that bit 0 of rot is requester ptr
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        j     = int'(ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        idx   = OW'(j);
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner FSM and single-driver mux for a shared bus.
// Bounded hold per owner and one dead cycle between owners.
module shared_bus_arbiter
  import shared_bus_arbiter_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int DW       = 8,
  parameter  int MAX_HOLD = 8,
  localparam int OW       = ow_of(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]  gnt,
  output logic [DW-1:0]     bus_data,
  output logic              bus_valid,
  output logic [OW-1:0]     bus_owner,
  output logic              timeout_pulse
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t             state;
  logic [OW-1:0]      ptr;
  logic [OW-1:0]      next_ptr;
  logic [HW-1:0]      hold_cnt;
  logic               hold_done;
  logic               pick_found;
  logic [OW-1:0]      pick_idx;
  logic [MAX_REQ-1:0] pick_oh;

  rr_picker #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_oh   = onehot(32'(pick_idx));
  assign hold_done = (hold_cnt == HW'(MAX_HOLD - 1));
  assign next_ptr  = (bus_owner == OW'(N_REQ - 1))
                   ? '0 : bus_owner + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      gnt           <= '0;
      bus_owner     <= '0;
      timeout_pulse <= 1'b0;
      ptr           <= '0;
      hold_cnt      <= '0;
    end else begin
      timeout_pulse <= 1'b0;
      unique case (state)
        IDLE, TURN: begin
          if (pick_found) begin
            state     <= OWN;
            gnt       <= pick_oh[N_REQ-1:0];
            bus_owner <= pick_idx;
            hold_cnt  <= '0;
          end else begin
            state <= IDLE;
            gnt   <= '0;
          end
        end
        OWN: begin
          hold_cnt <= hold_cnt + 1'b1;
          // bus_valid is the owner's live request
          if (!bus_valid || hold_done) begin
            state         <= TURN;
            gnt           <= '0;
            ptr           <= next_ptr;
            timeout_pulse <= bus_valid;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus_data = bus_data
               | (req_data[i*DW +: DW] & {DW{gnt[i]}});
    end
  end

  assign bus_valid = |(gnt & req);

endmodule
